// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one op to the multi-stage ALU, then captures its result and flags and presents a writeback.
// Define ALU_OPCOUNT_EN to add the completed-op counter on op_count.
module alu_issue_ctrl #(
    parameter int SLACK = 1,
    parameter int RD_W  = 4
) (
    input  logic            wire_clock,
    input  logic            wire_reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [5:0]      req_op,
    input  logic [31:0]     req_a,
    input  logic [31:0]     req_b,
    input  logic            req_use_carry,
    input  logic [2:0]      req_shift,
    input  logic            req_dec,
    input  logic [RD_W-1:0] req_rd,
    output logic            enable_alu,
    output logic [5:0]      alu_op,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic            alu_use_carry,
    output logic [2:0]      alu_shift,
    output logic            alu_dec,
    output logic [15:0]     alu_fr_in,
    input  logic [31:0]     alu_m2,
    input  logic [15:0]     alu_fr_out,
    output logic            wb_valid,
    output logic            wb_write,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data,
    output logic            wb_err,
    output logic [15:0]     fr_q,
    output logic [31:0]     op_count
);
    localparam logic [5:0] OP_SETFR  = 6'b000110;
    localparam logic [5:0] OP_INCDEC = 6'b100100;
    localparam logic [5:0] OP_CMP    = 6'b010110;
    localparam logic [5:0] OP_DIV    = 6'b100011;
    localparam logic [5:0] OP_MOD    = 6'b100101;

    typedef enum logic [1:0] {IDLE, RUN, CAPT, WB} state_t;

    state_t          state, state_nx;
    logic            live;
    logic [2:0]      cnt;
    logic [RD_W-1:0] rd_q;
    logic [1:0]      lat;
    logic            accept;
    logic            div0;
    logic            writes;

    // Stage count per opcode; zero marks an opcode the ALU does not implement.
    function automatic logic [1:0] lat_of(input logic [5:0] op);
        case (op)
            6'b000110, 6'b100100, 6'b010110, 6'b010000: lat_of = 2'd1;
            6'b100000, 6'b100010, 6'b100011, 6'b100101, 6'b010010,
            6'b010011, 6'b010100, 6'b010101, 6'b011101: lat_of = 2'd2;
            6'b100001: lat_of = 2'd3;
            default: lat_of = 2'd0;
        endcase
    endfunction

    assign lat    = lat_of(req_op);
    assign accept = req_valid && req_ready;
    assign div0   = (alu_op == OP_DIV || alu_op == OP_MOD) && alu_fr_out[9];
    assign writes = alu_op != OP_CMP && alu_op != OP_SETFR;

    always_ff @(posedge wire_clock or negedge wire_reset_n) begin
        if (!wire_reset_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (lat != 2'd0) ? RUN : WB;
            RUN:  if (cnt == 3'd1) state_nx = CAPT;
            CAPT: state_nx = WB;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = live && state == IDLE;
        enable_alu = state == RUN;
        wb_valid   = state == WB;
        alu_fr_in  = (alu_op == OP_SETFR) ? alu_a[15:0] : fr_q;
    end

    // live keeps req_ready low until the first edge after reset release.
    always_ff @(posedge wire_clock or negedge wire_reset_n) begin
        if (!wire_reset_n) begin
            live          <= 1'b0;
            cnt           <= 3'd0;
            rd_q          <= '0;
            alu_op        <= 6'd0;
            alu_a         <= 32'd0;
            alu_b         <= 32'd0;
            alu_use_carry <= 1'b0;
            alu_shift     <= 3'd0;
            alu_dec       <= 1'b0;
            wb_write      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= 32'd0;
            wb_err        <= 1'b0;
            fr_q          <= 16'h0000;
        end else begin
            live <= 1'b1;
            if (accept) begin
                alu_op        <= req_op;
                alu_a         <= req_a;
                alu_b         <= req_b;
                alu_use_carry <= req_use_carry;
                alu_shift     <= req_shift;
                alu_dec       <= req_dec;
                rd_q          <= req_rd;
                cnt           <= 3'(lat) + 3'(SLACK);
            end else if (state == RUN) begin
                cnt <= cnt - 3'd1;
            end
            if (accept && lat == 2'd0) begin
                wb_rd    <= req_rd;
                wb_data  <= 32'd0;
                wb_write <= 1'b0;
                wb_err   <= 1'b1;
            end
            if (state == CAPT) begin
                wb_rd    <= rd_q;
                wb_data  <= alu_m2;
                wb_write <= writes && !div0;
                wb_err   <= div0;
                if (alu_op != OP_INCDEC) fr_q <= alu_fr_out;
            end
        end
    end

`ifdef ALU_OPCOUNT_EN
    always_ff @(posedge wire_clock or negedge wire_reset_n) begin
        if (!wire_reset_n) op_count <= 32'd0;
        else if (state == WB) op_count <= op_count + 32'd1;
    end
`else
    assign op_count = 32'h0;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench with a transaction-level model and an ALU stub driving m2/FR_out.
module tb_alu_issue_ctrl;
    localparam int SLACK = 1;
    localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100001, MUL = 6'b100010, DIV = 6'b100011;
    localparam logic [5:0] MOD = 6'b100101, INC = 6'b100100, CMP = 6'b010110, SETFR = 6'b000110;
    localparam logic [5:0] SHR = 6'b010000, ANDOP = 6'b010010, BAD = 6'b111111;

    logic clk = 1'b0, rst_n;
    logic req_valid, req_ready, req_use_carry, req_dec;
    logic [5:0] req_op;
    logic [31:0] req_a, req_b;
    logic [2:0] req_shift;
    logic [3:0] req_rd;
    logic enable_alu, alu_use_carry, alu_dec;
    logic [5:0] alu_op;
    logic [31:0] alu_a, alu_b, alu_m2;
    logic [2:0] alu_shift;
    logic [15:0] alu_fr_in, alu_fr_out, fr_q;
    logic wb_valid, wb_write, wb_err;
    logic [3:0] wb_rd;
    logic [31:0] wb_data, op_count;

    int tests = 0, fails = 0, cyc = 0;
    int acc_cyc = -10, wb_cyc = -10, n_en = 0, rel_cyc = 0, fr_sw = 0;
    int en_cnt = 0, low_run = 0, e_cnt = 0;
    logic prev_en = 1'b0, seen_en = 1'b0, en_e;
    logic [15:0] fr_old = 16'h0, fr_new = 16'h0, e_fi;
    logic [31:0] e_data, e_a, e_b;
    logic e_write, e_err, e_uc, e_dec;
    logic [3:0] e_rd;
    logic [5:0] e_op;
    logic [2:0] e_sh;

    alu_issue_ctrl #(.SLACK(SLACK), .RD_W(4)) dut (
        .wire_clock(clk), .wire_reset_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_use_carry(req_use_carry), .req_shift(req_shift), .req_dec(req_dec), .req_rd(req_rd),
        .enable_alu(enable_alu), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_use_carry(alu_use_carry), .alu_shift(alu_shift), .alu_dec(alu_dec), .alu_fr_in(alu_fr_in),
        .alu_m2(alu_m2), .alu_fr_out(alu_fr_out),
        .wb_valid(wb_valid), .wb_write(wb_write), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err),
        .fr_q(fr_q), .op_count(op_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached limit 100000", $time);
        $fatal(1);
    end

    // Stand-in ALU: FR bit 11 carry, 12 zero, 6 borrow, 9 divide-by-zero, 15:13 gt/eq/lt.
    function automatic logic [47:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                            input logic uc, input logic dc, input logic [15:0] fi);
        logic [32:0] s;
        logic [31:0] m;
        logic [15:0] f;
        f = fi;
        m = a ^ b ^ {26'd0, op};
        case (op)
            ADD: begin
                s = {1'b0, a} + {1'b0, b} + {32'd0, uc & fi[11]};
                m = s[31:0]; f[11] = s[32]; f[12] = m == 0;
            end
            SUB: begin m = (a >= b) ? a - b : 32'd0; f[6] = a < b; f[12] = m == 0; end
            DIV: begin m = (b == 0) ? 32'd0 : a / b; f[9] = b == 0; end
            MOD: begin m = (b == 0) ? 32'd0 : a % b; f[9] = b == 0; end
            INC: m = dc ? a - 32'd1 : a + 32'd1;
            CMP: f[15:13] = {a > b, a == b, a < b};
            default: ;
        endcase
        return {f, m};
    endfunction

    always_comb {alu_fr_out, alu_m2} = alu_fn(alu_op, alu_a, alu_b, alu_use_carry, alu_dec, alu_fr_in);

    function automatic int lat_of(input logic [5:0] op);
        if (op inside {SETFR, INC, CMP, SHR}) return 1;
        if (op inside {ADD, MUL, DIV, MOD, ANDOP, 6'b010011, 6'b010100, 6'b010101, 6'b011101}) return 2;
        if (op == SUB) return 3;
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, req);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic uc, input logic [2:0] sh, input logic dc, input logic [3:0] rd);
        logic [15:0] f;
        logic [31:0] m;
        logic known, dz;
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_use_carry = uc; req_shift = sh; req_dec = dc; req_rd = rd;
        req_valid = 1'b1;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        fr_old = (cyc >= fr_sw) ? fr_new : fr_old;
        known = lat_of(op) != 0;
        n_en = known ? lat_of(op) + SLACK : 0;
        acc_cyc = cyc;
        wb_cyc = known ? cyc + n_en + 1 : cyc;
        e_fi = (op == SETFR) ? a[15:0] : fr_old;
        {f, m} = alu_fn(op, a, b, uc, dc, e_fi);
        dz = (op == DIV || op == MOD) && f[9];
        e_data = known ? m : 32'd0;
        e_write = known && !(op inside {CMP, SETFR}) && !dz;
        e_err = !known || dz;
        e_rd = rd;
        fr_new = (known && op != INC) ? f : fr_old;
        fr_sw = wb_cyc;
        e_op = op; e_a = a; e_b = b; e_uc = uc; e_sh = sh; e_dec = dc;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && cyc <= wb_cyc; i++) @(negedge clk);
    endtask

    always @(negedge clk) if (rst_n) begin
        en_e = cyc >= acc_cyc && cyc < acc_cyc + n_en;
        chk("enable_alu", 32'(enable_alu), 32'(en_e));
        chk("wb_valid", 32'(wb_valid), 32'(cyc == wb_cyc));
        chk("req_ready", 32'(req_ready), 32'(cyc > rel_cyc && !(cyc >= acc_cyc && cyc <= wb_cyc)));
        chk("fr_q", 32'(fr_q), 32'((cyc >= fr_sw) ? fr_new : fr_old));
`ifdef ALU_OPCOUNT_EN
        chk("op_count", op_count, 32'(e_cnt));
`else
        chk("op_count", op_count, 32'd0);
`endif
        if (en_e) begin
            chk("alu_op", 32'(alu_op), 32'(e_op));
            chk("alu_a", alu_a, e_a);
            chk("alu_b", alu_b, e_b);
            chk("alu_ctl", 32'({alu_use_carry, alu_shift, alu_dec}), 32'({e_uc, e_sh, e_dec}));
            chk("alu_fr_in", 32'(alu_fr_in), 32'(e_fi));
        end
        if (cyc == wb_cyc) begin
            chk("wb_write", 32'(wb_write), 32'(e_write));
            chk("wb_err", 32'(wb_err), 32'(e_err));
            chk("wb_rd", 32'(wb_rd), 32'(e_rd));
            chk("wb_data", wb_data, e_data);
            e_cnt++;
        end
        if (enable_alu) begin
            if (!prev_en && seen_en) chk("en_gap", 32'(low_run >= 2), 32'd1);
            en_cnt++; seen_en = 1'b1; low_run = 0;
        end else low_run++;
        prev_en = enable_alu;
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 6'd0; req_a = 32'd0; req_b = 32'd0;
        req_use_carry = 1'b0; req_shift = 3'd0; req_dec = 1'b0; req_rd = 4'd0;
        #12;
        chk("rst_enable", 32'(enable_alu), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_wb", 32'({wb_valid, wb_write, wb_err, wb_rd}), 32'd0);
        chk("rst_outs", wb_data | alu_a | alu_b | 32'(alu_op) | 32'(fr_q) | 32'(alu_fr_in), 32'd0);
        chk("rst_op_count", op_count, 32'd0);
        #5 rst_n = 1'b1; rel_cyc = cyc;
        #1 chk("ready_before_edge", 32'(req_ready), 32'd0);

        en_cnt = 0; issue(ADD, 32'd5, 32'd7, 1'b0, 3'd0, 1'b0, 4'd3); wait_done();
        chk("add_en_cycles", 32'(en_cnt), 32'd3);
        chk("add_data", wb_data, 32'd12);
        chk("add_rd", 32'(wb_rd), 32'd3);
        chk("add_write", 32'(wb_write), 32'd1);
        chk("add_fr_c_z", 32'(fr_q[12:11]), 32'd0);

        en_cnt = 0; issue(SUB, 32'd3, 32'd5, 1'b0, 3'd0, 1'b0, 4'd4); wait_done();
        chk("sub_en_cycles", 32'(en_cnt), 32'd4);
        chk("sub_data", wb_data, 32'd0);
        chk("sub_fr6_fr12", 32'({fr_q[6], fr_q[12]}), 32'd3);
        chk("sub_write", 32'(wb_write), 32'd1);

        issue(DIV, 32'd10, 32'd0, 1'b0, 3'd0, 1'b0, 4'd5); wait_done();
        chk("div0_err_write", 32'({wb_err, wb_write}), 32'd2);
        chk("div0_fr9", 32'(fr_q[9]), 32'd1);
        issue(DIV, 32'd10, 32'd2, 1'b0, 3'd0, 1'b0, 4'd5); wait_done();
        chk("div_data", wb_data, 32'd5);
        chk("div_err", 32'(wb_err), 32'd0);
        issue(MOD, 32'd7, 32'd3, 1'b0, 3'd0, 1'b0, 4'd6); wait_done();
        chk("mod_data", wb_data, 32'd1);

        issue(CMP, 32'd9, 32'd4, 1'b0, 3'd0, 1'b0, 4'd1); wait_done();
        chk("cmp_write", 32'(wb_write), 32'd0);
        chk("cmp_fr", 32'(fr_q[15:13]), 32'b100);
        issue(SETFR, 32'h0000_0800, 32'd0, 1'b0, 3'd0, 1'b0, 4'd1); wait_done();
        chk("setfr_fr", 32'(fr_q), 32'h0800);
        chk("setfr_write", 32'(wb_write), 32'd0);
        issue(ADD, 32'd1, 32'd1, 1'b1, 3'd0, 1'b0, 4'd2); wait_done();
        chk("addc_data", wb_data, 32'd3);

        en_cnt = 0; issue(BAD, 32'd1, 32'd2, 1'b0, 3'd0, 1'b0, 4'd7); wait_done();
        chk("bad_en_cycles", 32'(en_cnt), 32'd0);
        chk("bad_err_write", 32'({wb_err, wb_write}), 32'd2);
        chk("bad_rd", 32'(wb_rd), 32'd7);

        issue(SHR, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 3'd5, 1'b0, 4'd8); wait_done();
        issue(MUL, 32'd6, 32'd3, 1'b1, 3'd2, 1'b1, 4'd9); wait_done();

        issue(INC, 32'd41, 32'd0, 1'b0, 3'd0, 1'b0, 4'd1);
        issue(INC, 32'd41, 32'd0, 1'b0, 3'd0, 1'b1, 4'd2); wait_done();
        chk("dec_data", wb_data, 32'd40);
        chk("dec_rd", 32'(wb_rd), 32'd2);

        issue(SETFR, 32'h0000_1234, 32'd0, 1'b0, 3'd0, 1'b0, 4'd1); wait_done();
        chk("setfr2_fr", 32'(fr_q), 32'h1234);
        issue(ADD, 32'd2, 32'd3, 1'b0, 3'd0, 1'b0, 4'd4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        acc_cyc = -10; wb_cyc = -10; n_en = 0; fr_old = 16'h0; fr_new = 16'h0; fr_sw = 0; e_cnt = 0;
        #1;
        chk("midrst_enable", 32'(enable_alu), 32'd0);
        chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
        chk("midrst_fr", 32'(fr_q), 32'd0);
        chk("midrst_op_count", op_count, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1; rel_cyc = cyc;
        issue(INC, 32'd7, 32'd0, 1'b0, 3'd0, 1'b0, 4'd3); wait_done();
        chk("post_rst_inc", wb_data, 32'd8);
        issue(ANDOP, 32'hFF, 32'h0F, 1'b0, 3'd1, 1'b0, 4'd5); wait_done();
`ifdef ALU_OPCOUNT_EN
        chk("op_count_two", op_count, 32'd2);
`else
        chk("op_count_off", op_count, 32'd0);
`endif
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
